// File: rtl/nmi_timer.sv
// nmi_timer: nmi responder with a prescaled 32-bit compare timer and a level match interrupt.
// Define NMI_TIMER_WAIT_EN to insert a WAIT state, which gives a 2-cycle access latency.
module nmi_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        nmi_valid,
  input  logic [31:0] nmi_addr,
  input  logic [31:0] nmi_wdata,
  input  logic [3:0]  nmi_wstrb,
  output logic [31:0] nmi_rdata,
  output logic        nmi_ready,
  output logic        irq_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic en, ie, oneshot, match;
  logic [15:0] pscr, pcnt;
  logic [31:0] cmp, cnt, rd_val;
  logic [2:0] sel;
  logic accept, wr, rd_load, tick, hit, unused;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] m;
    m = old;
    for (int i = 0; i < 4; i++) if (strb[i]) m[8*i +: 8] = nw[8*i +: 8];
    return m;
  endfunction
  assign sel = nmi_addr[4:2];
  assign accept = state == IDLE && nmi_valid;
  assign wr = accept && |nmi_wstrb;
`ifdef NMI_TIMER_WAIT_EN
  assign rd_load = state == WAIT && ~|nmi_wstrb;
`else
  assign rd_load = accept && ~|nmi_wstrb;
`endif
  assign tick = en && pcnt == pscr;
  assign hit = tick && cnt == cmp;
  assign irq_o = match && ie;
  assign unused = ^{nmi_addr[31:5], nmi_addr[1:0]};
  always_comb
    rd_val = sel == 3'd0 ? {29'd0, oneshot, ie, en} :
             sel == 3'd1 ? {16'd0, pscr} :
             sel == 3'd2 ? cmp :
             sel == 3'd3 ? cnt :
             sel == 3'd4 ? {31'd0, match} : 32'd0;
  // Software writes are placed after the hardware updates so they take priority; MATCH set beats W1C.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      nmi_ready <= 1'b0;
      nmi_rdata <= '0;
      en <= 1'b0;
      ie <= 1'b0;
      oneshot <= 1'b0;
      match <= 1'b0;
      pscr <= '0;
      pcnt <= '0;
      cmp <= '1;
      cnt <= '0;
    end else begin
`ifdef NMI_TIMER_WAIT_EN
      state <= state == IDLE ? (nmi_valid ? WAIT : IDLE) : state == WAIT ? RESP : IDLE;
      nmi_ready <= state == WAIT;
`else
      state <= accept ? RESP : IDLE;
      nmi_ready <= accept;
`endif
      if (rd_load) nmi_rdata <= rd_val;
      pcnt <= (tick || (wr && sel == 3'd1)) ? '0 : pcnt + {15'd0, en};
      if (tick) cnt <= hit ? '0 : cnt + 32'd1;
      if (hit) match <= 1'b1;
      else if (wr && sel == 3'd4 && nmi_wstrb[0] && nmi_wdata[0]) match <= 1'b0;
      if (hit && oneshot) en <= 1'b0;
      if (wr && sel == 3'd0 && nmi_wstrb[0]) {oneshot, ie, en} <= nmi_wdata[2:0];
      if (wr && sel == 3'd1)
        pscr <= {nmi_wstrb[1] ? nmi_wdata[15:8] : pscr[15:8], nmi_wstrb[0] ? nmi_wdata[7:0] : pscr[7:0]};
      if (wr && sel == 3'd2) cmp <= merge(cmp, nmi_wdata, nmi_wstrb);
      if (wr && sel == 3'd3) cnt <= merge(cnt, nmi_wdata, nmi_wstrb);
    end
endmodule

// File: tb/tb_nmi_timer.sv
// tb_nmi_timer: directed and randomized checks of nmi_timer against a register-level reference model.
module tb_nmi_timer;
`ifdef NMI_TIMER_WAIT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic nmi_valid = 1'b0;
  logic [31:0] nmi_addr = '0;
  logic [31:0] nmi_wdata = '0;
  logic [3:0] nmi_wstrb = '0;
  logic [31:0] nmi_rdata;
  logic nmi_ready, irq_o;
  int n_tests = 0;
  int n_fail = 0;
  nmi_timer dut (
    .clk_i(clk_i), .rst_i(rst_i), .nmi_valid(nmi_valid), .nmi_addr(nmi_addr),
    .nmi_wdata(nmi_wdata), .nmi_wstrb(nmi_wstrb), .nmi_rdata(nmi_rdata),
    .nmi_ready(nmi_ready), .irq_o(irq_o)
  );
  always #5 clk_i = ~clk_i;
  // Reference model: m_reg holds CTRL, PSCR, CMP, CNT, STAT exactly as software sees them.
  logic [31:0] m_reg [5];
  logic [31:0] m_nx [5];
  logic [15:0] m_pcnt;
  logic [31:0] m_rdata;
  logic [2:0] m_o;
  logic m_tick, m_hit, m_wr;
  int m_phase;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_reg = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
      m_pcnt = '0;
      m_phase = 0;
      m_rdata = '0;
    end else begin
      m_nx = m_reg;
      m_o = nmi_addr[4:2];
      m_tick = m_reg[0][0] && m_pcnt == m_reg[1][15:0];
      m_hit = m_tick && m_reg[3] == m_reg[2];
      if (m_reg[0][0]) m_pcnt = m_tick ? 16'd0 : m_pcnt + 16'd1;
      if (m_tick) m_nx[3] = m_hit ? 32'd0 : m_reg[3] + 32'd1;
      m_wr = m_phase == 0 && nmi_valid && nmi_wstrb != 4'd0;
      if (m_wr && m_o == 3'd4 && nmi_wstrb[0] && nmi_wdata[0]) m_nx[4] = 32'd0;
      if (m_hit) begin
        m_nx[4] = 32'd1;
        if (m_reg[0][2]) m_nx[0][0] = 1'b0;
      end
      if (m_wr && m_o < 3'd4) begin
        for (int b = 0; b < 4; b++) if (nmi_wstrb[b]) m_nx[m_o][8*b +: 8] = nmi_wdata[8*b +: 8];
        m_nx[0] = m_nx[0] & 32'h7;
        m_nx[1] = m_nx[1] & 32'hFFFF;
        if (m_o == 3'd1) m_pcnt = 16'd0;
      end
      if ((LAT == 1 ? (m_phase == 0 && nmi_valid) : m_phase == 1) && nmi_wstrb == 4'd0)
        m_rdata = m_o < 3'd5 ? m_reg[m_o] : 32'd0;
      m_phase = m_phase == 0 ? (nmi_valid ? 1 : 0) : m_phase < LAT ? m_phase + 1 : 0;
      m_reg = m_nx;
    end
  end
  task automatic bus(input logic [2:0] o, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    int n;
    n = 0;
    @(negedge clk_i);
    nmi_valid = 1'b1;
    nmi_addr = {27'($urandom), o, 2'b00};
    nmi_wdata = d;
    nmi_wstrb = s;
    do begin
      @(negedge clk_i);
      n++;
    end while (!nmi_ready && n < 8);
    r = nmi_rdata;
    n_tests++;
    if (n != LAT || nmi_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL latency off=%0d: ready after %0d cycles (ready=%b), required %0d", o, n, nmi_ready, LAT);
    end
    if (s == 4'd0) begin
      n_tests++;
      if (r !== m_rdata) begin
        n_fail++;
        $display("FAIL rdata off=%0d: got %h, required %h", o, r, m_rdata);
      end
    end
    nmi_valid = 1'b0;
    nmi_wstrb = 4'd0;
    @(negedge clk_i);
    n_tests++;
    if (nmi_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_width off=%0d: ready=%b on second cycle, required 0", o, nmi_ready);
    end
  endtask
  task automatic do_reset;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask
  task automatic test_reset;
    logic [31:0] r;
    logic [31:0] exp [8];
    exp = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (nmi_ready !== 1'b0 || nmi_rdata !== 32'd0 || irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rdata=%h irq=%b, required 0 0 0", nmi_ready, nmi_rdata, irq_o);
    end
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus(3'(i), 32'd0, 4'd0, r);
      n_tests++;
      if (r !== exp[i]) begin
        n_fail++;
        $display("FAIL reset_value off=%0d: got %h, required %h", i, r, exp[i]);
      end
    end
  endtask
  task automatic test_periodic;
    logic [31:0] r;
    logic seen;
    do_reset;
    bus(3'd2, 32'd5, 4'hF, r);
    bus(3'd1, 32'd0, 4'hF, r);
    bus(3'd0, 32'd3, 4'hF, r);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      seen |= irq_o;
      n_tests++;
      if (irq_o !== (m_reg[4][0] & m_reg[0][1])) begin
        n_fail++;
        $display("FAIL periodic_irq cycle %0d: got %b, required %b", i, irq_o, m_reg[4][0] & m_reg[0][1]);
      end
    end
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL periodic_match: irq never rose, required 1");
    end
    bus(3'd3, 32'd0, 4'd0, r);
    bus(3'd0, 32'd2, 4'hF, r);
    bus(3'd4, 32'd1, 4'h1, r);
    n_tests++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_irq: got %b, required 0", irq_o);
    end
    bus(3'd4, 32'd0, 4'd0, r);
    n_tests++;
    if (r !== 32'd0) begin
      n_fail++;
      $display("FAIL w1c_stat: got %h, required 0", r);
    end
  endtask
  task automatic test_oneshot;
    logic [31:0] r;
    do_reset;
    bus(3'd1, 32'd3, 4'hF, r);
    bus(3'd2, 32'd2, 4'hF, r);
    bus(3'd0, 32'd5, 4'hF, r);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      n_tests++;
      if (irq_o !== 1'b0) begin
        n_fail++;
        $display("FAIL oneshot_irq cycle %0d: got %b, required 0", i, irq_o);
      end
    end
    bus(3'd0, 32'd0, 4'd0, r);
    n_tests++;
    if (r !== 32'd4) begin
      n_fail++;
      $display("FAIL oneshot_ctrl: got %h, required 4", r);
    end
    bus(3'd3, 32'd0, 4'd0, r);
    n_tests++;
    if (r !== 32'd0) begin
      n_fail++;
      $display("FAIL oneshot_cnt: got %h, required 0", r);
    end
    bus(3'd4, 32'd0, 4'd0, r);
    n_tests++;
    if (r !== 32'd1) begin
      n_fail++;
      $display("FAIL oneshot_stat: got %h, required 1", r);
    end
  endtask
  task automatic test_cnt_write;
    logic [31:0] r;
    do_reset;
    bus(3'd1, 32'd999, 4'hF, r);
    bus(3'd0, 32'd1, 4'hF, r);
    bus(3'd3, 32'h1234_5678, 4'b0010, r);
    bus(3'd3, 32'd0, 4'd0, r);
    n_tests++;
    if (r !== 32'h0000_5600) begin
      n_fail++;
      $display("FAIL cnt_strobe: got %h, required 00005600", r);
    end
    bus(3'd1, 32'd0, 4'hF, r);
    bus(3'd3, 32'hABCD_0123, 4'hF, r);
    bus(3'd3, 32'd0, 4'd0, r);
    n_tests++;
    if (r !== 32'hABCD_0123 + 32'(2 * LAT)) begin
      n_fail++;
      $display("FAIL cnt_collision: got %h, required %h", r, 32'hABCD_0123 + 32'(2 * LAT));
    end
  endtask
  task automatic test_wrap;
    logic [31:0] r;
    do_reset;
    bus(3'd2, 32'd0, 4'hF, r);
    bus(3'd3, 32'hFFFF_FFFF, 4'hF, r);
    bus(3'd1, 32'd19, 4'hF, r);
    bus(3'd0, 32'd1, 4'hF, r);
    repeat (22) @(negedge clk_i);
    bus(3'd3, 32'd0, 4'd0, r);
    n_tests++;
    if (r !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_cnt: got %h, required 0", r);
    end
    bus(3'd4, 32'd0, 4'd0, r);
    n_tests++;
    if (r !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_nomatch: got %h, required 0", r);
    end
    repeat (15) @(negedge clk_i);
    bus(3'd4, 32'd0, 4'd0, r);
    n_tests++;
    if (r !== 32'd1) begin
      n_fail++;
      $display("FAIL wrap_match: got %h, required 1", r);
    end
    bus(3'd3, 32'd0, 4'd0, r);
    n_tests++;
    if (r !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_cnt_after_match: got %h, required 0", r);
    end
  endtask
  task automatic test_reset_mid;
    logic [31:0] r;
    logic [31:0] exp [5];
    int n;
    exp = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
    do_reset;
    bus(3'd2, 32'd5, 4'hF, r);
    bus(3'd1, 32'd0, 4'hF, r);
    bus(3'd0, 32'd3, 4'hF, r);
    repeat (10) @(negedge clk_i);
    n_tests++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL premid_irq: got %b, required 1", irq_o);
    end
    nmi_valid = 1'b1;
    nmi_addr = 32'd8;
    nmi_wstrb = 4'd0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!nmi_ready && n < 8);
    n_tests++;
    if (nmi_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_resp: ready=%b, required 1", nmi_ready);
    end
    rst_i = 1'b1;
    #1;
    n_tests++;
    if (nmi_ready !== 1'b0 || irq_o !== 1'b0 || nmi_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset: ready=%b irq=%b rdata=%h, required 0 0 0", nmi_ready, irq_o, nmi_rdata);
    end
    @(negedge clk_i);
    nmi_valid = 1'b0;
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus(3'(i), 32'd0, 4'd0, r);
      n_tests++;
      if (r !== exp[i]) begin
        n_fail++;
        $display("FAIL post_reset off=%0d: got %h, required %h", i, r, exp[i]);
      end
    end
  endtask
  task automatic test_random;
    logic [31:0] r, d;
    logic [3:0] s;
    logic [2:0] o;
    do_reset;
    for (int k = 0; k < 400; k++) begin
      o = 3'($urandom_range(0, 7));
      s = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      d = $urandom;
      if (o == 3'd0) d = 32'($urandom_range(0, 7));
      if (o == 3'd1) d = 32'($urandom_range(0, 3));
      if (o == 3'd2 || o == 3'd3) d = 32'($urandom_range(0, 12));
      bus(o, d, s, r);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk_i);
        n_tests++;
        if (irq_o !== (m_reg[4][0] & m_reg[0][1])) begin
          n_fail++;
          $display("FAIL random_irq iter %0d: got %b, required %b", k, irq_o, m_reg[4][0] & m_reg[0][1]);
        end
      end
    end
  endtask
  initial begin
    test_reset;
    test_periodic;
    test_oneshot;
    test_cnt_write;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nmi_timer.md
# nmi_timer

Memory-mapped timer that responds on the native memory interface (nmi) driven by the management core. Sits behind the nmi address decoder as a responder, serves register reads/writes with a fixed-latency `ready` pulse, and counts prescaled clock ticks up to a compare value. On a match it raises a level interrupt that feeds one bit of the core's `irq_i` vector.

## Interface
- No parameters. The address decoder selects the block; only `addr[4:2]` is decoded here.
- `clk_i`  in  1  system clock; single clock domain.
- `rst_i`  in  1  asynchronous, active-high reset.
- `nmi`  `nmi_if.slave`  —  `valid` (in, 1), `addr` (in, 32), `wdata` (in, 32), `wstrb` (in, 4; all-zero = read), `rdata` (out, 32), `ready` (out, 1).
- `irq_o`  out  1  match interrupt, level, active-high.

## Operation
- Register map (word offsets by `addr[4:2]`):
  - 0x00 CTRL: [0] EN, [1] IE, [2] ONESHOT; others read 0.
  - 0x04 PSCR: [15:0] divisor minus 1.
  - 0x08 CMP: 32-bit compare value.
  - 0x0C CNT: 32-bit counter, read/write.
  - 0x10 STAT: [0] MATCH, write-1-to-clear.
  - 0x14–0x1C: read 0, writes ignored.
- Writes honour `wstrb` per byte. STAT uses only byte 0.
- Prescaler `pcnt` (16 bit):
  - While EN=1: when `pcnt == PSCR`, `pcnt` <= 0 and a one-cycle tick is generated; otherwise `pcnt` increments.
  - While EN=0: `pcnt` holds.
- On a tick:
  - If `CNT == CMP`: CNT <= 0 and MATCH <= 1. If ONESHOT=1, EN <= 0 as well.
  - Otherwise: CNT <= CNT + 1, wrapping mod 2^32.
- `irq_o = MATCH & IE`, driven from flops only.
- Responder FSM:
  - IDLE: `ready`=0. When `valid`=1, the request is sampled at the clock edge. A write commits at that edge; for a read, `rdata` is registered at that edge. Go to RESP.
  - RESP: `ready`=1 for exactly one cycle, then return to IDLE.
- Simultaneous events:
  - Software write to CNT and a tick in the same cycle: the write wins.
  - Write to CTRL.EN and an ONESHOT clear in the same cycle: the write wins.
  - W1C to MATCH and a hardware set in the same cycle: the set wins (MATCH stays 1).
  - Any write to PSCR resets `pcnt` to 0.
- Reset (at any time, including mid-transaction): FSM returns to IDLE and the in-flight request is dropped.

## Timing
- Reset values:
  - `ready` 0, `rdata` 0, `irq_o` 0.
  - CTRL 0, PSCR 0, CMP 0xFFFF_FFFF, CNT 0, STAT 0, `pcnt` 0.
- Access latency is 1 cycle: `ready` goes high the cycle after `valid` is first sampled high in IDLE.
- The initiator holds `valid`/`addr`/`wdata`/`wstrb` stable until `ready` and drops `valid` after it. The block never issues back-to-back `ready`s. A new request is accepted no earlier than the cycle after `ready`.
- `rdata` is valid only while `ready`=1. It holds its value otherwise.
- Tick period is PSCR+1 cycles. With PSCR=0, a tick occurs every cycle while EN=1.
- A match is first visible on `irq_o` in the cycle after the tick edge that sets MATCH.
- After a CNT write, the next tick counts from the written value.

## Configuration
- `NMI_TIMER_WAIT_EN`:
  - Defined: adds a WAIT state between IDLE and RESP, making access latency 2 cycles (`ready` in the 3rd cycle of `valid`). Writes commit at the IDLE→WAIT edge; `rdata` is registered at the WAIT→RESP edge.
  - Undefined: latency is 1 cycle as specified above.

## Test plan
- Reset then read every offset 0x00–0x1C -> 0, 0, 0xFFFF_FFFF, 0, 0, 0, 0, 0. Each access shows `ready` for exactly 1 cycle, 1 cycle after `valid` (2 with `NMI_TIMER_WAIT_EN`).
- Write CMP=5, PSCR=0, CTRL=0x3 -> MATCH sets on the 6th tick; `irq_o`=1 one cycle later; CNT reads 0; counting continues. Write STAT=1 -> `irq_o`=0.
- PSCR=3, CMP=2, CTRL=0x5 (ONESHOT) -> match after 12 cycles; CTRL.EN reads 0; CNT stays 0 and `irq_o` stays 0 because IE=0.
- Write CNT=0x1234_5678 with `wstrb`=0b0010 from CNT=0 while ticking -> CNT reads 0x0000_5600 (+ ticks since). A write colliding with a tick yields exactly the written value.
- CNT=0xFFFF_FFFF, CMP=0 (forced via writes), tick -> CNT wraps to 0; the next tick matches.
- Assert `rst_i` during RESP with CTRL=0x3 -> `ready` drops immediately and all registers return to reset values. The next read of CTRL returns 0 with normal latency.
